clk_div_sched: RTL and testbench

//  Round-robin scheduler that shares one clk_div instance between N_REQ requesters.
//  - Each requester asks for a burst of LEN divided ticks.
//  - The block grants one requester at a time and drives clk_div.enable.
//  - It forwards clk_div.clk_pulse to the granted requester and counts the ticks.
//  - It signals completion, then rotates priority to the next requester.

---
 rtl/clk_div_sched.sv | 167 ++++++++++++++++
 tb/tb_clk_div_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Brief    : Round-robin owner arbitration for one shared clk_div; meters LEN-tick bursts.
// Revision : 1.0
// ============================================================================
module clk_div_sched #(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 8,
  parameter int DIVIDER = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       tick,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   div_enable,
  input  logic                   div_pulse
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0] C_N_REQ = (PTR_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The divider itself lives outside; DIVIDER only fixes the tick spacing seen on div_pulse.
  generate
    if (N_REQ < 2 || N_REQ > 8 || LEN_W < 1 || DIVIDER < 1) begin : g_bad_param
      $error("clk_div_sched: parameter out of range");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic                 div_enable_q, div_enable_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     sel_q, sel_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;

  logic                 arb_found;
  logic [PTR_W-1:0]     arb_sel;
  logic [PTR_W-1:0]     arb_cand;
  logic [LEN_W-1:0]     arb_len;

  // Modular add that also works when N_REQ is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= C_N_REQ) s = s - C_N_REQ;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = rr_ptr_q;
    arb_cand  = rr_ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      arb_cand = ptr_inc(rr_ptr_q, PTR_W'(k));
      if (req[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
    arb_len = len[int'(arb_sel)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    div_enable_d = div_enable_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    remaining_d  = remaining_q;
    case (state_q)
      S_IDLE: begin
        grant_d      = '0;
        div_enable_d = 1'b0;
        if (arb_found) begin
          sel_d       = arb_sel;
          remaining_d = arb_len;
          if (arb_len == '0) begin
            state_d = S_DONE;
            done_d  = onehot(arb_sel);
          end else begin
            state_d      = S_RUN;
            grant_d      = onehot(arb_sel);
            div_enable_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort wins over a coincident final pulse; that pulse still reaches tick.
        if (!req[sel_q]) begin
          state_d      = S_IDLE;
          grant_d      = '0;
          div_enable_d = 1'b0;
          rr_ptr_d     = ptr_inc(sel_q, PTR_W'(1));
        end else if (div_pulse) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d      = S_DONE;
            grant_d      = '0;
            div_enable_d = 1'b0;
            done_d       = onehot(sel_q);
          end
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        grant_d      = '0;
        div_enable_d = 1'b0;
        rr_ptr_d     = ptr_inc(sel_q, PTR_W'(1));
      end
      default: begin
        state_d      = S_IDLE;
        grant_d      = '0;
        div_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      div_enable_q <= 1'b0;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      div_enable_q <= div_enable_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      remaining_q  <= remaining_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign div_enable = div_enable_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign tick       = grant_q & {N_REQ{div_pulse && (state_q == S_RUN)}};

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Brief    : Scenario bench for clk_div_sched with a behavioural clk_div (DIVIDER=3).
// Revision : 1.0
// ============================================================================
module tb_clk_div_sched;

  localparam int N_REQ   = 4;
  localparam int LEN_W   = 8;
  localparam int DIVIDER = 3;

  logic                   clk_in;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       tick;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   div_enable;
  logic                   div_pulse;

  clk_div_sched #(
    .N_REQ  (N_REQ),
    .LEN_W  (LEN_W),
    .DIVIDER(DIVIDER)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req       (req),
    .len       (len),
    .grant     (grant),
    .tick      (tick),
    .done      (done),
    .busy      (busy),
    .div_enable(div_enable),
    .div_pulse (div_pulse)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Divider model: parked at 0b011 while disabled, pulses whenever it sits at 0b011.
  logic [DIVIDER-1:0] div_cnt;
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)           div_cnt <= 3'b011;
    else if (!div_enable) div_cnt <= 3'b011;
    else                  div_cnt <= div_cnt + 3'd1;
  end
  assign div_pulse = div_enable && (div_cnt == 3'b011);

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_done;
    logic [3:0]  vec;
    logic [31:0] cycle;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_got;
  ev_t mon_want;

  task automatic push_ev(input logic is_done, input logic [3:0] vec, input int c);
    ev_t e;
    e.is_done = is_done;
    e.vec     = vec;
    e.cycle   = 32'(c);
    exp_q.push_back(e);
  endtask

  // Every tick/done observed is matched in order against the expected stream.
  always @(negedge clk_in) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mon_got.is_done = (k == 1);
        mon_got.vec     = (k == 1) ? done : tick;
        mon_got.cycle   = 32'(cyc);
        if (mon_got.vec !== 4'b0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind=%0d vec=%b cyc=%0d, required no event",
                     mon_got.is_done, mon_got.vec, mon_got.cycle);
          end else begin
            mon_want = exp_q.pop_front();
            if (mon_got !== mon_want) begin
              bad++;
              $display("FAIL sb_event: got kind=%0d vec=%b cyc=%0d, required kind=%0d vec=%b cyc=%0d",
                       mon_got.is_done, mon_got.vec, mon_got.cycle,
                       mon_want.is_done, mon_want.vec, mon_want.cycle);
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    repeat (2) @(negedge clk_in);
    total++; if (grant !== 4'b0)    begin bad++; $display("FAIL reset_grant: got %b required 0000", grant); end
    total++; if (done !== 4'b0)     begin bad++; $display("FAIL reset_done: got %b required 0000", done); end
    total++; if (div_enable !== 1'b0) begin bad++; $display("FAIL reset_div_enable: got %b required 0", div_enable); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (tick !== 4'b0)     begin bad++; $display("FAIL reset_tick: got %b required 0000", tick); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single_burst();
    int c0;
    do_reset();
    c0 = cyc;
    len[7:0] = 8'd3;
    req      = 4'b0001;
    push_ev(1'b0, 4'b0001, c0 + 1);
    push_ev(1'b0, 4'b0001, c0 + 9);
    push_ev(1'b0, 4'b0001, c0 + 17);
    push_ev(1'b1, 4'b0001, c0 + 18);
    wait_cyc(c0 + 1);
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b required 0001", grant); end
    total++; if (div_enable !== 1'b1) begin bad++; $display("FAIL single_div_enable: got %b required 1", div_enable); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy: got %b required 1", busy); end
    wait_cyc(c0 + 5);
    len[7:0] = 8'd9;  // must be ignored mid-burst
    wait_cyc(c0 + 18);
    total++; if (grant !== 4'b0)    begin bad++; $display("FAIL single_grant_done: got %b required 0000", grant); end
    total++; if (div_enable !== 1'b0) begin bad++; $display("FAIL single_enable_done: got %b required 0", div_enable); end
    req = 4'b0000;
    wait_cyc(c0 + 19);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_busy_after: got %b required 0", busy); end
    wait_cyc(c0 + 30);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_round_robin();
    int c0;
    do_reset();
    c0  = cyc;
    len = {4{8'd1}};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_ev(1'b0, 4'b0001 << (k % 4), c0 + 1 + 3*k);
      push_ev(1'b1, 4'b0001 << (k % 4), c0 + 2 + 3*k);
    end
    for (int k = 0; k < 5; k++) begin
      wait_cyc(c0 + 1 + 3*k);
      total++;
      if (grant !== (4'b0001 << (k % 4))) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b required %b", k, grant, 4'b0001 << (k % 4));
      end
    end
    wait_cyc(c0 + 14);
    req = 4'b0000;
    wait_cyc(c0 + 18);
    total++; if (grant !== 4'b0)    begin bad++; $display("FAIL rr_grant_end: got %b required 0000", grant); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_zero_len();
    int c0;
    do_reset();
    c0  = cyc;
    len = {8'd7, 8'd0, 8'd7, 8'd7};
    req = 4'b0100;
    push_ev(1'b1, 4'b0100, c0 + 1);
    wait_cyc(c0 + 1);
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL zero_busy: got %b required 1", busy); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL zero_grant: got %b required 0000", grant); end
    req = 4'b0000;
    for (int k = 1; k < 5; k++) begin
      wait_cyc(c0 + k);
      total++;
      if (div_enable !== 1'b0) begin bad++; $display("FAIL zero_div_enable_c%0d: got %b required 0", k, div_enable); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zero_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_abort();
    int c0;
    do_reset();
    c0  = cyc;
    len = {8'd1, 8'd1, 8'd1, 8'd5};
    req = 4'b0001;
    push_ev(1'b0, 4'b0001, c0 + 1);
    push_ev(1'b0, 4'b0001, c0 + 9);
    wait_cyc(c0 + 10);
    req = 4'b0000;
    wait_cyc(c0 + 11);
    total++; if (grant !== 4'b0)      begin bad++; $display("FAIL abort_grant: got %b required 0000", grant); end
    total++; if (div_enable !== 1'b0) begin bad++; $display("FAIL abort_div_enable: got %b required 0", div_enable); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL abort_busy: got %b required 0", busy); end
    // rr_ptr must now be 1, so requester 1 wins over 0.
    wait_cyc(c0 + 12);
    len[7:0] = 8'd1;
    req      = 4'b0011;
    push_ev(1'b0, 4'b0010, c0 + 13);
    push_ev(1'b1, 4'b0010, c0 + 14);
    push_ev(1'b0, 4'b0001, c0 + 16);
    push_ev(1'b1, 4'b0001, c0 + 17);
    wait_cyc(c0 + 13);
    total++; if (grant !== 4'b0010)   begin bad++; $display("FAIL abort_next_grant: got %b required 0010", grant); end
    wait_cyc(c0 + 14);
    req = 4'b0001;
    wait_cyc(c0 + 17);
    req = 4'b0000;
    wait_cyc(c0 + 22);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_run();
    int c0;
    do_reset();
    c0  = cyc;
    len = {8'd4, 8'd0, 8'd0, 8'd0};
    req = 4'b0100;
    push_ev(1'b1, 4'b0100, c0 + 1);
    wait_cyc(c0 + 1);
    req = 4'b0000;
    wait_cyc(c0 + 2);
    req = 4'b1000;
    push_ev(1'b0, 4'b1000, c0 + 3);
    wait_cyc(c0 + 6);
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0)      begin bad++; $display("FAIL midrst_grant: got %b required 0000", grant); end
    total++; if (div_enable !== 1'b0) begin bad++; $display("FAIL midrst_div_enable: got %b required 0", div_enable); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    req = 4'b1001;
    len = {8'd1, 8'd0, 8'd0, 8'd1};
    wait_cyc(c0 + 8);
    rst_n = 1'b1;
    push_ev(1'b0, 4'b0001, c0 + 9);
    push_ev(1'b1, 4'b0001, c0 + 10);
    wait_cyc(c0 + 9);
    total++; if (grant !== 4'b0001)   begin bad++; $display("FAIL midrst_regrant: got %b required 0001", grant); end
    wait_cyc(c0 + 10);
    req = 4'b0000;
    wait_cyc(c0 + 14);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_max_len();
    int c0;
    do_reset();
    c0  = cyc;
    len = {8'd0, 8'd0, 8'd255, 8'd0};
    req = 4'b0010;
    for (int k = 0; k < 255; k++) push_ev(1'b0, 4'b0010, c0 + 1 + 8*k);
    push_ev(1'b1, 4'b0010, c0 + 2 + 8*254);
    wait_cyc(c0 + 2 + 8*254);
    req = 4'b0000;
    wait_cyc(c0 + 2 + 8*254 + 6);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL max_busy_end: got %b required 0", busy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL max_pending: got %0d unseen events required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_zero_len();
    test_abort();
    test_reset_mid_run();
    test_max_len();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
